// File: rtl/char_sweep_sequencer.sv
// Inverter-cell characterization sequencer: walks a slope x load-cap grid, pulses the cell input
// low at each point, verifies the inverted response and streams one delay record per point.
module char_sweep_sequencer #(
  parameter int unsigned NB_SLOPES   = 7,
  parameter int unsigned NB_CAPA     = 7,
  parameter int unsigned TICK_CYCLES = 10,
  parameter int unsigned IDX_W       = 3,
  parameter int unsigned MEAS_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [IDX_W-1:0]  slope_idx,
  output logic [IDX_W-1:0]  capa_idx,
  output logic              din,
  input  logic              dut_dout,
  input  logic [MEAS_W-1:0] meas_value,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [IDX_W-1:0]  rec_slope,
  output logic [IDX_W-1:0]  rec_capa,
  output logic [MEAS_W-1:0] rec_meas
);

  localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(TICK_CYCLES - 1);
  localparam logic [IDX_W-1:0] SLOPE_LAST = IDX_W'(NB_SLOPES - 1);
  localparam logic [IDX_W-1:0] CAPA_LAST  = IDX_W'(NB_CAPA - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SLOPE_SET, S_CAPA_SET, S_FALL, S_CHECK, S_EMIT, S_RISE, S_DONE, S_ERROR
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   slope_q, slope_d, capa_q, capa_d;
  logic [IDX_W-1:0]   rec_slope_q, rec_slope_d, rec_capa_q, rec_capa_d;
  logic [MEAS_W-1:0]  rec_meas_q, rec_meas_d;
  logic               tick_zero;

  assign tick_zero = (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_SLOPE_SET;
      S_SLOPE_SET: if (tick_zero) state_d = S_CAPA_SET;
      S_CAPA_SET:  if (tick_zero) state_d = S_FALL;
      S_FALL:      if (tick_zero) state_d = S_CHECK;
      S_CHECK:     state_d = dut_dout ? S_EMIT : S_ERROR;
      S_EMIT:      if (rec_ready) state_d = S_RISE;
      S_RISE: begin
        if (tick_zero) begin
          if (capa_q < CAPA_LAST)        state_d = S_CAPA_SET;
          else if (slope_q < SLOPE_LAST) state_d = S_SLOPE_SET;
          else                           state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Every wait state is entered through a state change, so entry alone reloads the tick counter.
  always_comb begin
    cnt_d       = tick_zero ? cnt_q : cnt_q - 1'b1;
    slope_d     = slope_q;
    capa_d      = capa_q;
    rec_slope_d = rec_slope_q;
    rec_capa_d  = rec_capa_q;
    rec_meas_d  = rec_meas_q;
    if (state_d != state_q &&
        (state_d == S_SLOPE_SET || state_d == S_CAPA_SET ||
         state_d == S_FALL || state_d == S_RISE)) begin
      cnt_d = CNT_LOAD;
    end
    if (state_d == S_SLOPE_SET && state_q != S_SLOPE_SET) begin
      slope_d = (state_q == S_RISE) ? slope_q + 1'b1 : '0;
      capa_d  = '0;
    end
    if (state_d == S_CAPA_SET && state_q == S_RISE) capa_d = capa_q + 1'b1;
    if (state_q == S_SLOPE_SET && state_d == S_CAPA_SET) capa_d = '0;
    if (state_q == S_CHECK && dut_dout) begin
      rec_slope_d = slope_q;
      rec_capa_d  = capa_q;
      rec_meas_d  = meas_value;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      slope_q     <= '0;
      capa_q      <= '0;
      rec_slope_q <= '0;
      rec_capa_q  <= '0;
      rec_meas_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      slope_q     <= slope_d;
      capa_q      <= capa_d;
      rec_slope_q <= rec_slope_d;
      rec_capa_q  <= rec_capa_d;
      rec_meas_q  <= rec_meas_d;
    end
  end

  always_comb begin
    busy      = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
    done      = (state_q == S_DONE);
    err       = (state_q == S_ERROR);
    rec_valid = (state_q == S_EMIT);
    din       = !(state_q == S_FALL || state_q == S_CHECK || state_q == S_EMIT);
  end

  assign slope_idx = slope_q;
  assign capa_idx  = capa_q;
  assign rec_slope = rec_slope_q;
  assign rec_capa  = rec_capa_q;
  assign rec_meas  = rec_meas_q;

endmodule
